// File: rtl/game_keypad_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : game_keypad_scan_if
// Brief    : Keypad matrix lines and key-event outputs of game_keypad_scan.
// Revision : 1.0 - initial release
// ============================================================================
interface game_keypad_scan_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // master: the scanner (drives rows and key events)
    modport master (
        input  col,
        output row,
        output key_code,
        output key_valid,
        output key_held
    );

    // slave: keypad lines plus the game logic consuming key events
    modport slave (
        output col,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface
`default_nettype wire

// File: rtl/game_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : game_keypad_scan
// Brief    : 4x4 active-low keypad scanner with per-scan debounce and one-cycle
//            key events. Define KEYPAD_REPEAT_EN to add held-key auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module game_keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 200,
    parameter int REPEAT_RATE    = 40
) (
    input  wire logic            clk,
    input  wire logic            rst,
    game_keypad_scan_if.master   kp
);

    localparam int         c_div_w   = $clog2(SCAN_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [3:0] c_deb     = 4'(DEBOUNCE_SCANS);

    typedef enum logic [0:0] {
        S_RELEASED = 1'b0,
        S_PRESSED  = 1'b1
    } state_t;

    logic [3:0]         r_col_meta_q, r_col_sync_q;
    logic [c_div_w-1:0] r_div_cnt_q,  w_div_cnt_d;
    logic [1:0]         r_row_idx_q,  w_row_idx_d;
    logic [15:0]        r_snapshot_q, w_snapshot_d;
    logic               r_eval_q,     w_eval_d;
    logic               r_cand_vld_q, w_cand_vld_d;
    logic [3:0]         r_cand_code_q, w_cand_code_d;
    logic [3:0]         r_stab_cnt_q, w_stab_cnt_d;
    logic               r_acc_stb_q,  w_acc_stb_d;
    logic               r_acc_vld_q,  w_acc_vld_d;
    logic [3:0]         r_acc_code_q, w_acc_code_d;
    state_t             r_state_q,    w_state_d;
    logic [3:0]         r_key_code_q, w_key_code_d;
    logic               r_key_valid_q, w_key_valid_d;
    logic               r_key_held_q, w_key_held_d;

    logic               w_row_last;
    logic               w_res_vld;
    logic [3:0]         w_res_code;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] c_rep_delay = 16'(REPEAT_DELAY);
    localparam logic [15:0] c_rep_rate  = 16'(REPEAT_RATE);

    logic [15:0] r_rep_cnt_q, w_rep_cnt_d;
    logic        r_rep_armed_q, w_rep_armed_d;
    logic [15:0] w_rep_inc;
    logic [15:0] w_rep_target;

    assign w_rep_inc    = r_rep_cnt_q + 16'd1;
    assign w_rep_target = r_rep_armed_q ? c_rep_rate : c_rep_delay;
`else
    // Repeat timing has no effect in this build; the empty block only references it.
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_params_ignored
    end
`endif

    // ------------------------------------------------------------------
    // Row sequencing and column snapshot
    // ------------------------------------------------------------------
    assign w_row_last = (r_div_cnt_q == c_div_last);

    always_comb begin
        w_div_cnt_d  = w_row_last ? '0 : r_div_cnt_q + 1'b1;
        w_row_idx_d  = w_row_last ? r_row_idx_q + 2'd1 : r_row_idx_q;
        w_snapshot_d = r_snapshot_q;
        if (w_row_last) begin
            w_snapshot_d[{r_row_idx_q, 2'b00} +: 4] = ~r_col_sync_q;
        end
        w_eval_d = w_row_last && (r_row_idx_q == 2'd3);
    end

    // ------------------------------------------------------------------
    // Scan result: exactly one pressed key, anything else is NONE
    // ------------------------------------------------------------------
    assign w_res_vld = (r_snapshot_q != 16'd0) &&
                       ((r_snapshot_q & (r_snapshot_q - 16'd1)) == 16'd0);

    always_comb begin
        w_res_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_snapshot_q[i]) begin
                w_res_code = 4'(i);
            end
        end
        if (!w_res_vld) begin
            w_res_code = 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Debounce across full scans
    // ------------------------------------------------------------------
    always_comb begin
        w_cand_vld_d  = r_cand_vld_q;
        w_cand_code_d = r_cand_code_q;
        w_stab_cnt_d  = r_stab_cnt_q;
        w_acc_vld_d   = r_acc_vld_q;
        w_acc_code_d  = r_acc_code_q;
        if (r_eval_q) begin
            if ((w_res_vld == r_cand_vld_q) && (w_res_code == r_cand_code_q)) begin
                if (r_stab_cnt_q != c_deb) begin
                    w_stab_cnt_d = r_stab_cnt_q + 4'd1;
                end
            end else begin
                w_cand_vld_d  = w_res_vld;
                w_cand_code_d = w_res_code;
                w_stab_cnt_d  = 4'd1;
            end
            w_acc_vld_d  = w_res_vld;
            w_acc_code_d = w_res_code;
        end
        w_acc_stb_d = r_eval_q && (w_stab_cnt_d == c_deb);
    end

    // ------------------------------------------------------------------
    // Press/release FSM, fed once per scan by the accepted result
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_key_code_d  = r_key_code_q;
        w_key_valid_d = 1'b0;
        w_key_held_d  = r_key_held_q;
`ifdef KEYPAD_REPEAT_EN
        w_rep_cnt_d   = r_rep_cnt_q;
        w_rep_armed_d = r_rep_armed_q;
`endif
        if (r_acc_stb_q) begin
            case (r_state_q)
                S_RELEASED: begin
                    if (r_acc_vld_q) begin
                        w_key_code_d  = r_acc_code_q;
                        w_key_valid_d = 1'b1;
                        w_key_held_d  = 1'b1;
                        w_state_d     = S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_cnt_d   = 16'd0;
                        w_rep_armed_d = 1'b0;
`endif
                    end
                end
                S_PRESSED: begin
                    if (!r_acc_vld_q) begin
                        w_key_held_d  = 1'b0;
                        w_state_d     = S_RELEASED;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_cnt_d   = 16'd0;
                        w_rep_armed_d = 1'b0;
`endif
                    end else if (r_acc_code_q != r_key_code_q) begin
                        w_key_code_d  = r_acc_code_q;
                        w_key_valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_cnt_d   = 16'd0;
                        w_rep_armed_d = 1'b0;
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        // First repeat after REPEAT_DELAY scans, then every REPEAT_RATE.
                        if (w_rep_inc == w_rep_target) begin
                            w_key_valid_d = 1'b1;
                            w_rep_cnt_d   = 16'd0;
                            w_rep_armed_d = 1'b1;
                        end else begin
                            w_rep_cnt_d   = w_rep_inc;
                        end
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta_q  <= 4'hF;
            r_col_sync_q  <= 4'hF;
            r_div_cnt_q   <= '0;
            r_row_idx_q   <= 2'd0;
            r_snapshot_q  <= 16'd0;
            r_eval_q      <= 1'b0;
            r_cand_vld_q  <= 1'b0;
            r_cand_code_q <= 4'd0;
            r_stab_cnt_q  <= 4'd0;
            r_acc_stb_q   <= 1'b0;
            r_acc_vld_q   <= 1'b0;
            r_acc_code_q  <= 4'd0;
            r_state_q     <= S_RELEASED;
            r_key_code_q  <= 4'd0;
            r_key_valid_q <= 1'b0;
            r_key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt_q   <= 16'd0;
            r_rep_armed_q <= 1'b0;
`endif
        end else begin
            r_col_meta_q  <= kp.col;
            r_col_sync_q  <= r_col_meta_q;
            r_div_cnt_q   <= w_div_cnt_d;
            r_row_idx_q   <= w_row_idx_d;
            r_snapshot_q  <= w_snapshot_d;
            r_eval_q      <= w_eval_d;
            r_cand_vld_q  <= w_cand_vld_d;
            r_cand_code_q <= w_cand_code_d;
            r_stab_cnt_q  <= w_stab_cnt_d;
            r_acc_stb_q   <= w_acc_stb_d;
            r_acc_vld_q   <= w_acc_vld_d;
            r_acc_code_q  <= w_acc_code_d;
            r_state_q     <= w_state_d;
            r_key_code_q  <= w_key_code_d;
            r_key_valid_q <= w_key_valid_d;
            r_key_held_q  <= w_key_held_d;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt_q   <= w_rep_cnt_d;
            r_rep_armed_q <= w_rep_armed_d;
`endif
        end
    end

    assign kp.row       = ~(4'b0001 << r_row_idx_q);
    assign kp.key_code  = r_key_code_q;
    assign kp.key_valid = r_key_valid_q;
    assign kp.key_held  = r_key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_game_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_keypad_scan
// Brief    : Directed bench for game_keypad_scan with a keypad matrix model and
//            a scoreboard of expected key events (code and arrival cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_keypad_scan;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int REPEAT_DELAY   = 3;
    localparam int REPEAT_RATE    = 2;
    localparam int SCAN_CLKS      = 4 * SCAN_DIV;

    typedef struct {
        int code;
        int cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mask = 16'd0;
    logic [3:0]  w_col;
    logic [3:0]  exp_row;
    int          cyc = 0;
    int          sc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    bit          started = 1'b0;
    exp_t        exp_q[$];
    exp_t        got;

    always #5 clk = ~clk;

    game_keypad_scan_if u_if ();

    game_keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .kp  (u_if.master)
    );

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        w_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (u_if.row[r] == 1'b0) begin
                w_col = w_col & ~mask[r*4 +: 4];
            end
        end
    end
    assign u_if.col = w_col;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Row walk and key events are checked every cycle once reset has been applied.
    always @(negedge clk) begin
        if (started && !rst) begin
            exp_row = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            check("row", {28'd0, u_if.row}, {28'd0, exp_row});
            if (u_if.key_valid !== 1'b0) begin
                check("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check("pulse_code", {28'd0, u_if.key_code}, got.code);
                    check("pulse_cycle", cyc, got.cycle);
                end
            end
        end
    end

    task automatic expect_key(input int code, input int scan_no);
        exp_t e;
        e.code  = code;
        e.cycle = scan_no * SCAN_CLKS + 2;
        exp_q.push_back(e);
    endtask

    task automatic do_scans(input logic [15:0] m, input int n);
        mask = m;
        repeat (n * SCAN_CLKS) @(posedge clk);
        #1;
        sc += n;
    endtask

    // One more scan with the current keys, checking the state left by the previous scan.
    task automatic hold_check(input string tag, input logic held, input logic [3:0] code);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_held"}, {31'd0, u_if.key_held}, {31'd0, held});
        check({tag, "_code"}, {28'd0, u_if.key_code}, {28'd0, code});
        repeat (SCAN_CLKS - 2) @(posedge clk);
        #1;
        sc += 1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_row"},   {28'd0, u_if.row},      32'hE);
        check({tag, "_code"},  {28'd0, u_if.key_code}, 32'h0);
        check({tag, "_valid"}, {31'd0, u_if.key_valid}, 32'h0);
        check({tag, "_held"},  {31'd0, u_if.key_held}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");
        started = 1'b1;

        // Single press of key 9 (row 2, col 1), then release
        expect_key(9, sc + 2);
        do_scans(16'h0200, 2);
        hold_check("single_press", 1'b1, 4'd9);
        do_scans(16'h0000, 2);
        hold_check("single_release", 1'b0, 4'd9);

        // Bounce on key 5, then a steady hold
        for (int i = 0; i < 5; i++) begin
            do_scans(16'h0020, 1);
            do_scans(16'h0000, 1);
        end
        check("bounce_no_pulse", exp_q.size(), 0);
        expect_key(5, sc + 2);
        do_scans(16'h0020, 2);
        hold_check("bounce_steady", 1'b1, 4'd5);
        do_scans(16'h0000, 2);
        hold_check("bounce_release", 1'b0, 4'd5);

        // Two keys together are rejected; dropping one accepts the other
        do_scans(16'h0021, 3);
        hold_check("two_keys", 1'b0, 4'd5);
        expect_key(0, sc + 2);
        do_scans(16'h0001, 2);
        hold_check("two_keys_single", 1'b1, 4'd0);

        // Roll-over 0 -> 3 -> 12 without release
        expect_key(3, sc + 2);
        do_scans(16'h0008, 2);
        hold_check("rollover_3", 1'b1, 4'd3);
        expect_key(12, sc + 2);
        do_scans(16'h1000, 1);
        hold_check("rollover_mid", 1'b1, 4'd3);
        hold_check("rollover_12", 1'b1, 4'd12);
        do_scans(16'h0000, 2);
        hold_check("rollover_release", 1'b0, 4'd12);

        // Reset while key 7 is held and accepted
        expect_key(7, sc + 2);
        do_scans(16'h0080, 2);
        hold_check("pre_reset", 1'b1, 4'd7);
        check("pre_reset_queue", exp_q.size(), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sc = 0;
        check_reset_values("mid_reset");
        expect_key(7, sc + 2);
        do_scans(16'h0080, 2);
        hold_check("reaccept", 1'b1, 4'd7);
`ifdef KEYPAD_REPEAT_EN
        expect_key(7, 2 + REPEAT_DELAY);
        expect_key(7, 2 + REPEAT_DELAY + REPEAT_RATE);
        expect_key(7, 2 + REPEAT_DELAY + 2 * REPEAT_RATE);
        expect_key(7, 2 + REPEAT_DELAY + 3 * REPEAT_RATE);
`endif
        do_scans(16'h0080, 8);
        hold_check("long_hold", 1'b1, 4'd7);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
